// File: rtl/reg_wb_queue.sv
// Register-file write-back queue: merges ALU and load write requests into one
// registered write per cycle, and forwards pending data to the read ports.
module reg_wb_queue #(
  parameter int DEPTH     = 4,
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int DROP_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_addr,
  input  logic [DW-1:0]            alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [AW-1:0]            mem_addr,
  input  logic [DW-1:0]            mem_data,
  output logic                     mem_ready,
  output logic                     rf_write_reg,
  output logic [AW-1:0]            rf_w_addr,
  output logic [DW-1:0]            rf_w_data,
  input  logic [AW-1:0]            fwd_addr_a,
  input  logic [AW-1:0]            fwd_addr_b,
  output logic                     fwd_hit_a,
  output logic [DW-1:0]            fwd_data_a,
  output logic                     fwd_hit_b,
  output logic [DW-1:0]            fwd_data_b,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam bit DROP = (DROP_ZERO != 0);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, alu_slot, idx;
  logic [CW-1:0] free;
  logic [1:0]    num_push;
  logic          mem_push, alu_push, pop;
  logic          zero_a, zero_b;

  // Ready uses the pre-pop occupancy so a full queue never overflows even
  // when the head drains on the same edge.
  assign free      = CW'(DEPTH) - count;
  assign mem_ready = (free >= CW'(1));
  assign alu_ready = mem_valid ? (free >= CW'(2)) : (free >= CW'(1));
  assign mem_push  = mem_valid && mem_ready && !(DROP && (mem_addr == '0));
  assign alu_push  = alu_valid && alu_ready && !(DROP && (alu_addr == '0));
  assign num_push  = {1'b0, mem_push} + {1'b0, alu_push};
  assign alu_slot  = wr_ptr + PW'(mem_push);
  assign pop       = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign zero_a    = DROP && (fwd_addr_a == '0);
  assign zero_b    = DROP && (fwd_addr_b == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      rf_write_reg <= 1'b0;
      rf_w_addr    <= '0;
      rf_w_data    <= '0;
    end else begin
      if (pop) begin
        rf_write_reg <= 1'b1;
        rf_w_addr    <= addr_q[rd_ptr];
        rf_w_data    <= data_q[rd_ptr];
        rd_ptr       <= rd_ptr + PW'(1);
      end else begin
        rf_write_reg <= 1'b0;
      end
      if (mem_push) begin
        addr_q[wr_ptr] <= mem_addr;
        data_q[wr_ptr] <= mem_data;
      end
      if (alu_push) begin
        addr_q[alu_slot] <= alu_addr;
        data_q[alu_slot] <= alu_data;
      end
      wr_ptr <= wr_ptr + PW'(num_push);
      count  <= count + CW'(num_push) - CW'(pop);
    end
  end

  // Scan oldest to youngest so the last match (youngest write) wins; the
  // in-flight register-file write is older than anything still queued.
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_data_a = '0;
    fwd_hit_b  = 1'b0;
    fwd_data_b = '0;
    idx        = '0;
    if (rf_write_reg && (rf_w_addr == fwd_addr_a) && !zero_a) begin
      fwd_hit_a  = 1'b1;
      fwd_data_a = rf_w_data;
    end
    if (rf_write_reg && (rf_w_addr == fwd_addr_b) && !zero_b) begin
      fwd_hit_b  = 1'b1;
      fwd_data_b = rf_w_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if ((addr_q[idx] == fwd_addr_a) && !zero_a) begin
          fwd_hit_a  = 1'b1;
          fwd_data_a = data_q[idx];
        end
        if ((addr_q[idx] == fwd_addr_b) && !zero_b) begin
          fwd_hit_b  = 1'b1;
          fwd_data_b = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: a queue-based reference of pending writes
// plus a shadow register file checks handshakes, write order and forwarding.
module tb_reg_wb_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic [4:0]  alu_addr = '0, mem_addr = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready;
  logic        rf_write_reg;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;
  logic [4:0]  fwd_addr_a = '0, fwd_addr_b = '0;
  logic        fwd_hit_a, fwd_hit_b;
  logic [31:0] fwd_data_a, fwd_data_b;
  logic [2:0]  count;
  logic        full, empty;

  int num_checks = 0;
  int num_fails  = 0;

  ent_t        q[$];
  ent_t        infl;
  bit          infl_v = 1'b0;
  logic [31:0] model_rf [32];
  logic [31:0] dut_rf   [32];

  reg_wb_queue #(.DEPTH(DEPTH), .AW(5), .DW(32), .DROP_ZERO(1)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_write_reg(rf_write_reg), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b),
    .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
    .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Shadow register file driven only by the DUT's write port.
  always @(posedge clk) begin
    if (rf_write_reg) dut_rf[rf_w_addr] <= rf_w_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelFwd(input logic [4:0] a, output bit hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != 5'd0) begin
      if (infl_v && infl.addr == a) begin hit = 1'b1; d = infl.data; end
      foreach (q[i]) if (q[i].addr == a) begin hit = 1'b1; d = q[i].data; end
    end
  endtask

  task automatic checkState();
    bit          h;
    logic [31:0] d;
    checkOutput("rf_write_reg", rf_write_reg, infl_v);
    if (infl_v) begin
      checkOutput("rf_w_addr", rf_w_addr, infl.addr);
      checkOutput("rf_w_data", rf_w_data, infl.data);
    end
    checkOutput("count", count, q.size());
    checkOutput("empty", empty, q.size() == 0);
    checkOutput("full", full, q.size() == DEPTH);
    modelFwd(fwd_addr_a, h, d);
    checkOutput("fwd_hit_a", fwd_hit_a, h);
    checkOutput("fwd_data_a", fwd_data_a, d);
    modelFwd(fwd_addr_b, h, d);
    checkOutput("fwd_hit_b", fwd_hit_b, h);
    checkOutput("fwd_data_b", fwd_data_b, d);
  endtask

  // One clock cycle: drive at negedge, check ready, advance model at posedge,
  // check registered state at the following negedge.
  task automatic applyStimulus(input bit mv, input logic [4:0] ma, input logic [31:0] md,
                               input bit av, input logic [4:0] aa, input logic [31:0] ad,
                               output bit m_acc, output bit a_acc);
    int free;
    bit exp_mr, exp_ar;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    #1;
    free   = DEPTH - q.size();
    exp_mr = (free >= 1);
    exp_ar = mv ? (free >= 2) : (free >= 1);
    checkOutput("mem_ready", mem_ready, exp_mr);
    checkOutput("alu_ready", alu_ready, exp_ar);
    m_acc = mv && exp_mr;
    a_acc = av && exp_ar;
    @(posedge clk);
    if (infl_v) model_rf[infl.addr] = infl.data;
    if (q.size() > 0) begin infl = q.pop_front(); infl_v = 1'b1; end
    else infl_v = 1'b0;
    if (m_acc && ma != 5'd0) q.push_back('{ma, md});
    if (a_acc && aa != 5'd0) q.push_back('{aa, ad});
    @(negedge clk);
    mem_valid = 1'b0; alu_valid = 1'b0;
    checkState();
  endtask

  task automatic idle(input int n);
    bit ma, aa;
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, ma, aa);
  endtask

  initial begin
    bit          ma, aa;
    ent_t        pend[$];
    logic [31:0] d;
    for (int i = 0; i < 32; i++) begin model_rf[i] = '0; dut_rf[i] = '0; end

    // Reset state
    #1;
    checkOutput("rst_write_reg", rf_write_reg, 1'b0);
    checkOutput("rst_count", count, 3'd0);
    checkOutput("rst_empty", empty, 1'b1);
    checkOutput("rst_full", full, 1'b0);
    checkOutput("rst_w_addr", rf_w_addr, 5'd0);
    checkOutput("rst_w_data", rf_w_data, 32'd0);
    checkOutput("rst_fwd_hit_a", fwd_hit_a, 1'b0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Single ALU write: appears one cycle after the acceptance edge.
    applyStimulus(0, 0, 0, 1, 5'd3, 32'h11, ma, aa);
    checkOutput("t1_write_early", rf_write_reg, 1'b0);
    idle(1);
    checkOutput("t1_write", rf_write_reg, 1'b1);
    checkOutput("t1_addr", rf_w_addr, 5'd3);
    checkOutput("t1_data", rf_w_data, 32'h11);
    idle(1);
    checkOutput("t1_write_done", rf_write_reg, 1'b0);

    // Same-cycle mem+ALU to one address: mem first, ALU youngest for forwarding.
    fwd_addr_a = 5'd5; fwd_addr_b = 5'd3;
    applyStimulus(1, 5'd5, 32'hAA, 1, 5'd5, 32'hBB, ma, aa);
    checkOutput("t2_fwd_q", fwd_data_a, 32'hBB);
    idle(1);
    checkOutput("t2_first", rf_w_data, 32'hAA);
    checkOutput("t2_fwd_mix", fwd_data_a, 32'hBB);
    idle(1);
    checkOutput("t2_second", rf_w_data, 32'hBB);
    checkOutput("t2_fwd_infl", fwd_hit_a, 1'b1);
    idle(1);
    checkOutput("t2_fwd_clear", fwd_hit_a, 1'b0);

    // Two pushes per cycle: ALU stalls when only one slot is free; retry until all six go.
    for (int i = 0; i < 6; i++) pend.push_back('{5'(i + 10), 32'h100 + 32'(i)});
    for (int it = 0; it < 12 && pend.size() > 0; it++) begin
      if (pend.size() >= 2)
        applyStimulus(1, pend[0].addr, pend[0].data, 1, pend[1].addr, pend[1].data, ma, aa);
      else
        applyStimulus(1, pend[0].addr, pend[0].data, 0, 0, 0, ma, aa);
      if (ma && aa) begin pend.delete(0); pend.delete(0); end
      else if (ma) pend.delete(0);
    end
    checkOutput("t3_all_accepted", pend.size(), 0);
    idle(6);
    for (int i = 0; i < 6; i++)
      checkOutput("t3_rf", model_rf[i + 10], 32'h100 + 32'(i));

    // Address 0 write: handshakes but never stored or forwarded.
    fwd_addr_a = 5'd0;
    applyStimulus(0, 0, 0, 1, 5'd0, 32'hFF, ma, aa);
    checkOutput("t4_accepted", aa, 1'b1);
    checkOutput("t4_count", count, 3'd0);
    checkOutput("t4_fwd_hit", fwd_hit_a, 1'b0);
    idle(1);
    checkOutput("t4_no_write", rf_write_reg, 1'b0);

    // Reset mid-cycle with three queued entries and one in flight.
    fwd_addr_a = 5'd9;
    applyStimulus(1, 5'd7, 32'h70, 1, 5'd8, 32'h80, ma, aa);
    applyStimulus(1, 5'd9, 32'h90, 1, 5'd10, 32'hA0, ma, aa);
    checkOutput("t5_count_pre", count, 3'd3);
    #2 reset = 1'b1;
    #1;
    checkOutput("t5_write_reg", rf_write_reg, 1'b0);
    checkOutput("t5_count", count, 3'd0);
    checkOutput("t5_empty", empty, 1'b1);
    checkOutput("t5_fwd_hit", fwd_hit_a, 1'b0);
    q.delete();
    infl_v = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(3);

    // Fill/drain rounds with random addresses; file contents must match the model.
    for (int r = 0; r < 10; r++) begin
      fwd_addr_a = 5'($urandom_range(0, 31));
      fwd_addr_b = 5'($urandom_range(1, 31));
      for (int c = 0; c < 3; c++) begin
        d = $urandom;
        applyStimulus(1, 5'($urandom_range(0, 31)), d, 1, 5'($urandom_range(0, 31)), ~d, ma, aa);
      end
      idle(6);
    end
    idle(2);
    for (int i = 0; i < 32; i++) checkOutput($sformatf("t6_rf%0d", i), dut_rf[i], model_rf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
